param_seq_datapath: RTL and testbench

- Parametrised successor of the single-bus CPU datapath.
- Holds a NUM_REGS x DATA_W register file, Y/ZHigh/ZLow staging registers and HI/LO.
- Adds a built-in micro-sequencer that executes one register-register ALU instruction per start pulse over a fixed T-state sequence, with a busy/done handshake.
- The control unit issues start and no longer drives the per-cycle Rin/Rout strobes.

---
 rtl/param_seq_datapath.sv | 264 ++++++++++++++++++++++++++
 tb/tb_param_seq_datapath.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_seq_datapath.sv
// Parametrised single-bus datapath with a built-in T-state micro-sequencer.
// Optional zero/negative flags are compiled in when DP_FLAGS_EN is defined.
module param_seq_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [IDX_W-1:0]  ra,
  input  logic [IDX_W-1:0]  rb,
  input  logic [IDX_W-1:0]  rc,
  input  logic              ba,
  input  logic              ext_we,
  input  logic [IDX_W-1:0]  ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] bus_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_n
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [2:0]        state;
  logic [3:0]        op_q;
  logic [IDX_W-1:0]  ra_q;
  logic [IDX_W-1:0]  rb_q;
  logic [IDX_W-1:0]  rc_q;
  logic              ba_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] zh_q;
  logic [DATA_W-1:0] zl_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              done_q;
  logic              err_q;

  logic [DATA_W-1:0]   src_b;
  logic [DATA_W-1:0]   src_c;
  logic [DATA_W-1:0]   bus;
  logic                is_wide;
  logic                is_rsvd;
  logic [SH_W-1:0]     amt;
  logic [2*DATA_W-1:0] rot_src;
  logic [2*DATA_W-1:0] ror_w;
  logic [2*DATA_W-1:0] rol_w;
  logic [2*DATA_W-1:0] y_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   alu_lo;
  logic [DATA_W-1:0]   alu_hi;

  // Base-address mode masks only sequencer reads of R0, never the debug port.
  always_comb begin
    src_b = (ba_q && (rb_q == '0)) ? '0 : regs[rb_q];
    src_c = (ba_q && (rc_q == '0)) ? '0 : regs[rc_q];
  end

  always_comb begin
    bus = '0;
    case (state)
      S_T1:    bus = src_b;
      S_T2:    bus = src_c;
      S_T3:    bus = zl_q;
      S_T4:    bus = zh_q;
      default: bus = '0;
    endcase
  end

  always_comb begin
    is_wide = (op_q == OP_MUL) || (op_q == OP_DIV);
    is_rsvd = (op_q > OP_DIV);
  end

  // Rotates are taken from a doubled copy of Y so amount 0 needs no special case.
  always_comb begin
    amt     = bus[SH_W-1:0];
    rot_src = {y_q, y_q};
    ror_w   = rot_src >> amt;
    rol_w   = rot_src << amt;
    y_ext   = {{DATA_W{y_q[DATA_W-1]}}, y_q};
    b_ext   = {{DATA_W{bus[DATA_W-1]}}, bus};
    prod    = y_ext * b_ext;
  end

  always_comb begin
    quo = '0;
    rem = '0;
    if (bus == '0) begin
      quo = '1;
      rem = y_q;
    end else if ((y_q == MOST_NEG) && (bus == '1)) begin
      quo = y_q;
      rem = '0;
    end else begin
      quo = $signed(y_q) / $signed(bus);
      rem = $signed(y_q) % $signed(bus);
    end
  end

  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    case (op_q)
      OP_ADD:  alu_lo = y_q + bus;
      OP_SUB:  alu_lo = y_q - bus;
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_SHR:  alu_lo = y_q >> amt;
      OP_SHRA: alu_lo = $signed(y_q) >>> amt;
      OP_SHL:  alu_lo = y_q << amt;
      OP_ROR:  alu_lo = ror_w[DATA_W-1:0];
      OP_ROL:  alu_lo = rol_w[2*DATA_W-1:DATA_W];
      OP_NEG:  alu_lo = '0 - y_q;
      OP_NOT:  alu_lo = ~y_q;
      OP_MUL:  {alu_hi, alu_lo} = prod;
      OP_DIV: begin
        alu_lo = quo;
        alu_hi = rem;
      end
      default: begin
        alu_lo = '0;
        alu_hi = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      op_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      rc_q   <= '0;
      ba_q   <= 1'b0;
      y_q    <= '0;
      zh_q   <= '0;
      zl_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ext_we) begin
            regs[ext_addr] <= ext_data;
          end
          if (start) begin
            op_q  <= op;
            ra_q  <= ra;
            rb_q  <= rb;
            rc_q  <= rc;
            ba_q  <= ba;
            state <= S_T1;
          end
        end
        S_T1: begin
          y_q   <= bus;
          state <= S_T2;
        end
        S_T2: begin
          if (!is_rsvd) begin
            zh_q <= alu_hi;
            zl_q <= alu_lo;
          end
          state <= S_T3;
        end
        S_T3: begin
          if (is_wide) begin
            lo_q  <= bus;
            state <= S_T4;
          end else begin
            if (!is_rsvd) begin
              regs[ra_q] <= bus;
            end
            state  <= S_IDLE;
            done_q <= 1'b1;
            err_q  <= is_rsvd;
          end
        end
        S_T4: begin
          hi_q   <= bus;
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DP_FLAGS_EN
  logic fz_q;
  logic fn_q;

  // Wide ops flag the full {HI, LO}; LO is already stored when T4 runs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fz_q <= 1'b0;
      fn_q <= 1'b0;
    end else if ((state == S_T3) && !is_wide && !is_rsvd) begin
      fz_q <= (bus == '0);
      fn_q <= bus[DATA_W-1];
    end else if (state == S_T4) begin
      fz_q <= ({bus, lo_q} == '0);
      fn_q <= bus[DATA_W-1];
    end
  end

  assign flag_z = fz_q;
  assign flag_n = fn_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

  assign rd_data = regs[rd_addr];
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign bus_out = bus;
  assign busy    = (state != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_param_seq_datapath.sv
// Self-checking bench for param_seq_datapath against a behavioural ISA-level model.
module tb_param_seq_datapath;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [IW-1:0] ra = '0;
  logic [IW-1:0] rb = '0;
  logic [IW-1:0] rc = '0;
  logic          ba = 1'b0;
  logic          ext_we = 1'b0;
  logic [IW-1:0] ext_addr = '0;
  logic [DW-1:0] ext_data = '0;
  logic [IW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] hi_out;
  logic [DW-1:0] lo_out;
  logic [DW-1:0] bus_out;
  logic          busy;
  logic          done;
  logic          err;
  logic          flag_z;
  logic          flag_n;

  param_seq_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .ba(ba), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out),
    .bus_out(bus_out), .busy(busy), .done(done), .err(err),
    .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_regs [NR];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_fz = 1'b0;
  logic        m_fn = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
    m_fz = 1'b0;
    m_fn = 1'b0;
  endtask

  task automatic ext_load(input int idx, input logic [31:0] d);
    ext_we = 1'b1;
    ext_addr = idx[IW-1:0];
    ext_data = d;
    tick();
    ext_we = 1'b0;
    m_regs[idx] = d;
  endtask

  task automatic read_reg(input int idx, output logic [31:0] v);
    rd_addr = idx[IW-1:0];
    #1;
    v = rd_data;
  endtask

  function automatic logic [31:0] srcv(input int idx, input logic b_a);
    return (b_a && idx == 0) ? 32'h0 : m_regs[idx];
  endfunction

  // Instruction-level model: whole instruction effect, latency and err at once.
  task automatic model_exec(input logic [3:0] o, input int a_i, input int b_i, input int c_i,
                            input logic b_a, output logic e, output int lat);
    logic [31:0] a, b, r;
    int sh;
    longint p;
    a = srcv(b_i, b_a);
    b = srcv(c_i, b_a);
    sh = int'(b[4:0]);
    e = 1'b0;
    lat = 4;
    r = '0;
    if (o <= 4'd10) begin
      case (o)
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a >> sh;
        4'd5: r = int'(a) >>> sh;
        4'd6: r = a << sh;
        4'd7: begin r = a; repeat (sh) r = {r[0], r[31:1]}; end
        4'd8: begin r = a; repeat (sh) r = {r[30:0], r[31]}; end
        4'd9: r = 32'd0 - a;
        default: r = ~a;
      endcase
      m_regs[a_i] = r;
      m_fz = (r == 0);
      m_fn = r[31];
    end else if (o == 4'd11) begin
      p = longint'(int'(a)) * longint'(int'(b));
      m_hi = p[63:32];
      m_lo = p[31:0];
      lat = 5;
      m_fz = (p == 0);
      m_fn = m_hi[31];
    end else if (o == 4'd12) begin
      if (b == 0) begin
        m_lo = 32'hFFFF_FFFF;
        m_hi = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = a;
        m_hi = 0;
      end else begin
        m_lo = int'(a) / int'(b);
        m_hi = int'(a) % int'(b);
      end
      lat = 5;
      m_fz = ({m_hi, m_lo} == 64'd0);
      m_fn = m_hi[31];
    end else begin
      e = 1'b1;
    end
  endtask

  // Issues one start pulse; lat is the sample index where done appears (-1 on timeout).
  task automatic run_instr(input logic [3:0] o, input int a_i, input int b_i, input int c_i,
                           input logic b_a, output int lat, output logic e, output int bc);
    op = o;
    ra = a_i[IW-1:0];
    rb = b_i[IW-1:0];
    rc = c_i[IW-1:0];
    ba = b_a;
    start = 1'b1;
    tick();
    start = 1'b0;
    ext_we = 1'b0;
    lat = 1;
    bc = 0;
    while (!done && lat < 12) begin
      if (busy) bc++;
      tick();
      lat++;
    end
    if (!done) lat = -1;
    e = err;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clr = 1'b1;
    model_reset();
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if ({hi_out, lo_out, bus_out} !== '0) begin n_fail++; $display("FAIL reset_hilobus: got %h %h %h expected 0", hi_out, lo_out, bus_out); end
    n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", flag_z, flag_n); end
    for (int i = 0; i < NR; i++) begin
      read_reg(i, v);
      n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", i, v); end
    end
    #2 clr = 1'b0;
    tick();
  endtask

  task automatic test_add();
    logic [31:0] v;
    logic [31:0] exp_bus [4] = '{32'd7, 32'd5, 32'd12, 32'd0};
    logic [3:0] exp_busy = 4'b0111;
    logic [3:0] exp_done = 4'b1000;
    logic e;
    int lat, bc;
    ext_load(1, 32'd7);
    ext_load(2, 32'd5);
    op = 4'd0; ra = 4'd3; rb = 4'd1; rc = 4'd2; ba = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus_out !== exp_bus[i]) begin n_fail++; $display("FAIL add_bus_t%0d: got %h expected %h", i + 1, bus_out, exp_bus[i]); end
      n_checks++; if (busy !== exp_busy[i]) begin n_fail++; $display("FAIL add_busy_t%0d: got %b expected %b", i + 1, busy, exp_busy[i]); end
      n_checks++; if (done !== exp_done[i]) begin n_fail++; $display("FAIL add_done_t%0d: got %b expected %b", i + 1, done, exp_done[i]); end
      if (i < 3) tick();
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b expected 0", err); end
    model_exec(4'd0, 3, 1, 2, 1'b0, e, lat);
    read_reg(3, v);
    n_checks++; if (v !== 32'd12) begin n_fail++; $display("FAIL add_r3: got %h expected %h", v, 32'd12); end
`ifdef DP_FLAGS_EN
    n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b%b expected 00", flag_z, flag_n); end
`endif
    tick();
    // ext write in the start cycle must be visible to T1
    ext_we = 1'b1; ext_addr = 4'd1; ext_data = 32'd100;
    m_regs[1] = 32'd100;
    run_instr(4'd0, 8, 1, 2, 1'b0, lat, e, bc);
    model_exec(4'd0, 8, 1, 2, 1'b0, e, lat);
    read_reg(8, v);
    n_checks++; if (v !== 32'd105) begin n_fail++; $display("FAIL add_same_cycle_ext: got %h expected %h", v, 32'd105); end
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 3", bc); end
  endtask

  task automatic test_base_addr();
    logic [31:0] v;
    logic e;
    int lat, bc, ml;
    ext_load(0, 32'h1234);
    ext_load(2, 32'd5);
    run_instr(4'd0, 4, 0, 2, 1'b1, lat, e, bc);
    model_exec(4'd0, 4, 0, 2, 1'b1, e, ml);
    read_reg(4, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL ba1_r4: got %h expected %h", v, 32'd5); end
    read_reg(0, v);
    n_checks++; if (v !== 32'h1234) begin n_fail++; $display("FAIL ba1_rd_r0: got %h expected %h", v, 32'h1234); end
    run_instr(4'd0, 4, 0, 2, 1'b0, lat, e, bc);
    model_exec(4'd0, 4, 0, 2, 1'b0, e, ml);
    read_reg(4, v);
    n_checks++; if (v !== 32'h1239) begin n_fail++; $display("FAIL ba0_r4: got %h expected %h", v, 32'h1239); end
    n_checks++; if (lat !== ml) begin n_fail++; $display("FAIL ba0_latency: got %0d expected %0d", lat, ml); end
  endtask

  task automatic test_mul();
    logic [31:0] v;
    logic e;
    int lat, bc, ml;
    ext_load(1, 32'hFFFF_FFFE);
    ext_load(2, 32'd3);
    ext_load(9, 32'h55);
    run_instr(4'd11, 9, 1, 2, 1'b0, lat, e, bc);
    model_exec(4'd11, 9, 1, 2, 1'b0, e, ml);
    n_checks++; if (lo_out !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mul_lo: got %h expected %h", lo_out, 32'hFFFF_FFFA); end
    n_checks++; if (hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_hi: got %h expected %h", hi_out, 32'hFFFF_FFFF); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL mul_latency: got %0d expected 5", lat); end
    n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 4", bc); end
    read_reg(9, v);
    n_checks++; if (v !== 32'h55) begin n_fail++; $display("FAIL mul_ra_untouched: got %h expected %h", v, 32'h55); end
`ifdef DP_FLAGS_EN
    n_checks++; if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL mul_flags: got %b%b expected 01", flag_z, flag_n); end
`else
    n_checks++; if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL mul_flags_tied: got %b%b expected 00", flag_z, flag_n); end
`endif
  endtask

  task automatic test_div();
    logic [31:0] a_v [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] b_v [3] = '{32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] q_v [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] r_v [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0};
    logic e;
    int lat, bc, ml;
    for (int i = 0; i < 3; i++) begin
      ext_load(1, a_v[i]);
      ext_load(2, b_v[i]);
      run_instr(4'd12, 5, 1, 2, 1'b0, lat, e, bc);
      model_exec(4'd12, 5, 1, 2, 1'b0, e, ml);
      n_checks++; if (lo_out !== q_v[i]) begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, lo_out, q_v[i]); end
      n_checks++; if (hi_out !== r_v[i]) begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, hi_out, r_v[i]); end
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL div%0d_latency: got %0d expected 5", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [3:0] o;
    logic e, me, b_a;
    int lat, bc, ml, a_i, b_i, c_i;
    for (int it = 0; it < 48; it++) begin
      if ($urandom_range(0, 1) == 1)
        ext_load(int'($urandom_range(0, NR - 1)),
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom()));
      o = 4'($urandom_range(0, 15));
      a_i = int'($urandom_range(0, NR - 1));
      b_i = int'($urandom_range(0, NR - 1));
      c_i = int'($urandom_range(0, NR - 1));
      b_a = 1'($urandom_range(0, 1));
      run_instr(o, a_i, b_i, c_i, b_a, lat, e, bc);
      model_exec(o, a_i, b_i, c_i, b_a, me, ml);
      n_checks++; if (lat !== ml) begin n_fail++; $display("FAIL rnd%0d_latency op=%0d: got %0d expected %0d", it, o, lat, ml); end
      n_checks++; if (e !== me) begin n_fail++; $display("FAIL rnd%0d_err op=%0d: got %b expected %b", it, o, e, me); end
      read_reg(a_i, v);
      n_checks++; if (v !== m_regs[a_i]) begin n_fail++; $display("FAIL rnd%0d_reg op=%0d r%0d: got %h expected %h", it, o, a_i, v, m_regs[a_i]); end
      n_checks++; if ({hi_out, lo_out} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL rnd%0d_hilo op=%0d: got %h_%h expected %h_%h", it, o, hi_out, lo_out, m_hi, m_lo); end
`ifdef DP_FLAGS_EN
      n_checks++; if ({flag_z, flag_n} !== {m_fz, m_fn}) begin n_fail++; $display("FAIL rnd%0d_flags op=%0d: got %b%b expected %b%b", it, o, flag_z, flag_n, m_fz, m_fn); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [6] = '{4'd0, 4'd11, 4'd0, 4'd11, 4'd1, 4'd12};
    logic [31:0] v;
    logic e;
    int k, gap, guard, ml, dst;
    ext_load(1, 32'd40);
    ext_load(2, 32'd6);
    ext_load(15, 32'hCAFE);
    k = 0;
    op = seq[0]; ra = 4'd10; rb = 4'd1; rc = 4'd2; ba = 1'b0;
    start = 1'b1;
    tick();
    gap = 1;
    guard = 0;
    while (k < 6 && guard < 100) begin
      ext_we = busy;
      ext_addr = 4'd15;
      ext_data = 32'hDEAD;
      if (done) begin
        dst = int'(ra);
        model_exec(seq[k], dst, 1, 2, 1'b0, e, ml);
        n_checks++; if (gap !== ml) begin n_fail++; $display("FAIL b2b%0d_gap: got %0d expected %0d", k, gap, ml); end
        k++;
        if (k < 6) begin
          op = seq[k];
          ra = (k % 2 == 0) ? 4'd10 : 4'd11;
        end else begin
          start = 1'b0;
        end
        gap = 0;
      end
      tick();
      gap++;
      guard++;
    end
    ext_we = 1'b0;
    start = 1'b0;
    n_checks++; if (k !== 6) begin n_fail++; $display("FAIL b2b_completed: got %0d expected 6", k); end
    read_reg(15, v);
    n_checks++; if (v !== 32'hCAFE) begin n_fail++; $display("FAIL b2b_ext_while_busy: got %h expected %h", v, 32'hCAFE); end
    read_reg(10, v);
    n_checks++; if (v !== m_regs[10]) begin n_fail++; $display("FAIL b2b_r10: got %h expected %h", v, m_regs[10]); end
    read_reg(11, v);
    n_checks++; if (v !== m_regs[11]) begin n_fail++; $display("FAIL b2b_r11: got %h expected %h", v, m_regs[11]); end
    n_checks++; if ({hi_out, lo_out} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL b2b_hilo: got %h_%h expected %h_%h", hi_out, lo_out, m_hi, m_lo); end
    tick();
  endtask

  task automatic test_reserved();
    logic [31:0] v;
    logic e, sfz, sfn;
    int lat, bc, ml;
    ext_load(3, 32'h77);
    sfz = m_fz;
    sfn = m_fn;
    run_instr(4'd14, 3, 1, 2, 1'b0, lat, e, bc);
    model_exec(4'd14, 3, 1, 2, 1'b0, e, ml);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rsv_latency: got %0d expected 4", lat); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err: got %b expected 1", err); end
    for (int i = 0; i < NR; i++) begin
      read_reg(i, v);
      n_checks++; if (v !== m_regs[i]) begin n_fail++; $display("FAIL rsv_reg%0d: got %h expected %h", i, v, m_regs[i]); end
    end
    n_checks++; if ({hi_out, lo_out} !== {m_hi, m_lo}) begin n_fail++; $display("FAIL rsv_hilo: got %h_%h expected %h_%h", hi_out, lo_out, m_hi, m_lo); end
`ifdef DP_FLAGS_EN
    n_checks++; if ({flag_z, flag_n} !== {sfz, sfn}) begin n_fail++; $display("FAIL rsv_flags: got %b%b expected %b%b", flag_z, flag_n, sfz, sfn); end
`endif
    tick();
    n_checks++; if ({done, err} !== 2'b00) begin n_fail++; $display("FAIL rsv_pulse_width: got %b%b expected 00", done, err); end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    int seen;
    ext_load(1, 32'd9);
    ext_load(2, 32'd4);
    ext_load(7, 32'h99);
    op = 4'd1; ra = 4'd7; rb = 4'd1; rc = 4'd2; ba = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++; if (bus_out !== 32'd4) begin n_fail++; $display("FAIL abort_in_t2: got %h expected %h", bus_out, 32'd4); end
    #2 clr = 1'b1;
    #1;
    model_reset();
    n_checks++; if ({busy, done, err, flag_z, flag_n} !== 5'b0) begin n_fail++; $display("FAIL abort_ctl: got %b expected 00000", {busy, done, err, flag_z, flag_n}); end
    n_checks++; if ({hi_out, lo_out, bus_out} !== '0) begin n_fail++; $display("FAIL abort_data: got %h %h %h expected 0", hi_out, lo_out, bus_out); end
    read_reg(7, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL abort_r7: got %h expected 0", v); end
    #1 clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_base_addr();
    test_mul();
    test_div();
    test_random();
    test_back_to_back();
    test_reserved();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
